lfsr_noise_bank: RTL and testbench

Parametrised multi-channel LFSR noise source. It is the successor to the fixed 24-bit six-tap generator.
- One Fibonacci LFSR feeds a CHANNELS-deep register delay line, giving decorrelated signed noise words per voice.
- Adds a programmable rate divider for velocity/density control, runtime seed loading, and a sticky lock-up flag.
- Sits between the sample-rate strobe generator and the voice mixers.

---
 rtl/lfsr_pkg.sv | 21 ++
 rtl/lfsr_rate_div.sv | 32 +++
 rtl/lfsr_noise_bank.sv | 82 ++++++++
 tb/tb_lfsr_noise_bank.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared LFSR constants and the next-state helper for the noise-source blocks.
package lfsr_pkg;

    localparam int LFSR_MAX_W = 64;

    localparam logic [15:0] LFSR_TAPS16 = 16'hB400;
    localparam logic [15:0] LFSR_SEED16 = 16'hACE1;
    localparam logic [23:0] LFSR_TAPS24 = 24'hD8_0000;
    localparam logic [23:0] LFSR_SEED24 = 24'h9F_FFAF;
    localparam logic [31:0] LFSR_TAPS32 = 32'hA300_0000;
    localparam logic [31:0] LFSR_SEED32 = 32'h1357_9BDF;

    // Caller zero-extends state/taps and keeps only its own WIDTH LSBs of the result.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
        input logic [LFSR_MAX_W-1:0] state,
        input logic [LFSR_MAX_W-1:0] taps
    );
        return {state[LFSR_MAX_W-2:0], ^(state & taps)};
    endfunction

endpackage

// File: rtl/lfsr_rate_div.sv
// Strobe divider: asserts adv on every (rate+1)-th step_en strobe.
module lfsr_rate_div
    import lfsr_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step_en,
    input  logic [DIV_W-1:0] rate,
    input  logic             clr,
    output logic             adv
);

    logic [DIV_W-1:0] div_cnt;

    // >= rather than == so a rate lowered below the running count fires next strobe.
    assign adv = step_en && !clr && (div_cnt >= rate);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (clr) begin
            div_cnt <= '0;
        end else if (adv) begin
            div_cnt <= '0;
        end else if (step_en) begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/lfsr_noise_bank.sv
// Multi-channel noise source: one Fibonacci LFSR feeding a delay line of per-voice taps.
module lfsr_noise_bank
    import lfsr_pkg::*;
#(
    parameter int                WIDTH    = 24,
    parameter int                OUT_W    = 16,
    parameter int                CHANNELS = 6,
    parameter logic [WIDTH-1:0]  TAPS     = LFSR_TAPS24,
    parameter logic [WIDTH-1:0]  SEED     = LFSR_SEED24,
    parameter int                DIV_W    = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      step_en,
    input  logic [DIV_W-1:0]          rate,
    input  logic                      seed_load,
    input  logic [WIDTH-1:0]          seed,
    output logic [CHANNELS*OUT_W-1:0] ch_out,
    output logic                      valid,
    output logic                      lockup
);

    logic [WIDTH-1:0]      state;
    logic [LFSR_MAX_W-1:0] next_full;
    logic                  div_adv;
    logic                  do_adv;

    lfsr_rate_div #(.DIV_W(DIV_W)) u_div (
        .clk     (clk),
        .reset   (reset),
        .step_en (step_en),
        .rate    (rate),
        .clr     (seed_load),
        .adv     (div_adv)
    );

    assign next_full = lfsr_next(LFSR_MAX_W'(state), LFSR_MAX_W'(TAPS));
    // Seed load and lock-up recovery both take the clk; the delay line only moves on a real advance.
    assign do_adv    = div_adv && !seed_load && (state != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= SEED;
            valid  <= 1'b0;
            lockup <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (seed_load) begin
                state  <= (seed == '0) ? SEED : seed;
                lockup <= 1'b0;
            end else if (state == '0) begin
                state  <= SEED;
                lockup <= 1'b1;
            end else if (do_adv) begin
                state <= next_full[WIDTH-1:0];
                valid <= 1'b1;
            end
        end
    end

    // Channel CHANNELS-1 takes the outgoing state; each older channel takes its newer neighbour.
    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic        [WIDTH-1:0] tap;
        logic signed [OUT_W-1:0] word;

        if (k == CHANNELS - 1) begin : g_newest
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) tap <= '0;
                else if (do_adv) tap <= state;
            end
        end else begin : g_older
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) tap <= '0;
                else if (do_adv) tap <= g_ch[k+1].tap;
            end
        end

        assign word                     = tap[WIDTH-1 -: OUT_W];
        assign ch_out[k*OUT_W +: OUT_W] = word;
    end

endmodule

// File: tb/tb_lfsr_noise_bank.sv
// Self-checking bench for lfsr_noise_bank: directed scenarios plus a randomized model comparison.
module tb_lfsr_noise_bank;

    localparam int          WIDTH    = 24;
    localparam int          OUT_W    = 16;
    localparam int          CHANNELS = 6;
    localparam int          DIV_W    = 8;
    localparam logic [23:0] TAPS     = 24'hD8_0000;
    localparam logic [23:0] SEED     = 24'h9F_FFAF;

    logic                      clk = 1'b0;
    logic                      reset = 1'b0;
    logic                      step_en = 1'b0;
    logic [DIV_W-1:0]          rate = '0;
    logic                      seed_load = 1'b0;
    logic [WIDTH-1:0]          seed = '0;
    logic [CHANNELS*OUT_W-1:0] ch_out;
    logic                      valid;
    logic                      lockup;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lfsr_noise_bank #(
        .WIDTH(WIDTH), .OUT_W(OUT_W), .CHANNELS(CHANNELS),
        .TAPS(TAPS), .SEED(SEED), .DIV_W(DIV_W)
    ) dut (
        .clk(clk), .reset(reset), .step_en(step_en), .rate(rate),
        .seed_load(seed_load), .seed(seed),
        .ch_out(ch_out), .valid(valid), .lockup(lockup)
    );

    // Reference model: integer arithmetic over the spec's rules, delay line as a queue.
    logic [23:0] m_state;
    int          m_div;
    logic [23:0] m_dl[$];
    logic        m_valid;
    logic        m_lock;

    function automatic logic [23:0] ref_next(input logic [23:0] s);
        int par = 0;
        for (int i = 0; i < 24; i++)
            if (TAPS[i] && s[i]) par = par + 1;
        return 24'((s * 2) + (par % 2));
    endfunction

    function automatic logic [CHANNELS*OUT_W-1:0] ref_out();
        logic [CHANNELS*OUT_W-1:0] o = '0;
        for (int k = 0; k < CHANNELS; k++)
            o[k*OUT_W +: OUT_W] = m_dl[k][23:8];
        return o;
    endfunction

    task automatic model_reset();
        m_state = SEED; m_div = 0; m_valid = 0; m_lock = 0;
        m_dl.delete();
        for (int k = 0; k < CHANNELS; k++) m_dl.push_back(24'h0);
    endtask

    task automatic model_clock(input logic sl, input logic [23:0] sd, input logic se, input int r);
        m_valid = 0;
        if (sl) begin
            m_state = (sd == 0) ? SEED : sd;
            m_div = 0;
            m_lock = 0;
        end else if (m_state == 0) begin
            m_state = SEED;
            m_lock = 1;
        end else if (se) begin
            if (m_div >= r) begin
                m_dl.push_back(m_state);
                void'(m_dl.pop_front());
                m_state = ref_next(m_state);
                m_div = 0;
                m_valid = 1;
            end else begin
                m_div = m_div + 1;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step_en = 0; seed_load = 0; seed = '0; rate = '0;
        #1 reset = 0;
        cycle();
        cycle();
        reset = 1;
        model_reset();
    endtask

    task automatic strobe();
        step_en = 1;
        cycle();
        step_en = 0;
    endtask

    task automatic test_reset();
        reset = 0;
        cycle();
        checks++; if (ch_out !== '0) begin errors++; $display("FAIL reset_ch_out got=%h want=0", ch_out); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", valid); end
        checks++; if (lockup !== 1'b0) begin errors++; $display("FAIL reset_lockup got=%b want=0", lockup); end
        checks++; if (dut.state !== SEED) begin errors++; $display("FAIL reset_state got=%h want=%h", dut.state, SEED); end
        reset = 1;
        cycle();
        checks++; if (dut.state !== SEED) begin errors++; $display("FAIL idle_state got=%h want=%h", dut.state, SEED); end
    endtask

    task automatic test_first_step();
        do_reset();
        rate = 0;
        strobe();
        checks++; if (ch_out[5*OUT_W +: OUT_W] !== 16'h9FFF) begin errors++; $display("FAIL first_ch5 got=%h want=9fff", ch_out[5*OUT_W +: OUT_W]); end
        checks++; if (ch_out[5*OUT_W-1:0] !== '0) begin errors++; $display("FAIL first_ch0_4 got=%h want=0", ch_out[5*OUT_W-1:0]); end
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL first_valid got=%b want=1", valid); end
        checks++; if (dut.state !== 24'h3FFF5F) begin errors++; $display("FAIL first_state got=%h want=3fff5f", dut.state); end
        cycle();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL first_valid_width got=%b want=0", valid); end
    endtask

    task automatic test_rate_div();
        int pulses = 0;
        do_reset();
        rate = 3;
        for (int i = 1; i <= 12; i++) begin
            strobe();
            if (valid === 1'b1) pulses++;
            checks++;
            if (valid !== ((i % 4) == 0)) begin
                errors++; $display("FAIL rate3_strobe%0d valid got=%b want=%b", i, valid, (i % 4) == 0);
            end
            cycle();
        end
        checks++; if (pulses != 3) begin errors++; $display("FAIL rate3_pulses got=%0d want=3", pulses); end
        strobe();
        strobe();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rate_pre_change valid got=%b want=0", valid); end
        rate = 1;
        strobe();
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL rate_decrease valid got=%b want=1", valid); end
    endtask

    task automatic test_seed_load();
        do_reset();
        rate = 0;
        seed = 24'h000001; seed_load = 1; step_en = 1;
        cycle();
        seed_load = 0; step_en = 0;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL seed_valid got=%b want=0", valid); end
        checks++; if (dut.state !== 24'h000001) begin errors++; $display("FAIL seed_state got=%h want=000001", dut.state); end
        checks++; if (ch_out !== '0) begin errors++; $display("FAIL seed_dl got=%h want=0", ch_out); end
        strobe();
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL seed_next_valid got=%b want=1", valid); end
        checks++; if (ch_out[5*OUT_W +: OUT_W] !== 16'h0000) begin errors++; $display("FAIL seed_next_ch5 got=%h want=0000", ch_out[5*OUT_W +: OUT_W]); end
        checks++; if (dut.state !== 24'h000002) begin errors++; $display("FAIL seed_next_state got=%h want=000002", dut.state); end
        seed = 24'h0; seed_load = 1;
        cycle();
        seed_load = 0;
        checks++; if (dut.state !== SEED) begin errors++; $display("FAIL seed_zero_state got=%h want=%h", dut.state, SEED); end
        checks++; if (lockup !== 1'b0) begin errors++; $display("FAIL seed_zero_lockup got=%b want=0", lockup); end
    endtask

    task automatic test_lockup();
        do_reset();
        rate = 0;
        @(negedge clk);
        force dut.state = 24'h0;
        #1 release dut.state;
        cycle();
        checks++; if (dut.state !== SEED) begin errors++; $display("FAIL lockup_recover_state got=%h want=%h", dut.state, SEED); end
        checks++; if (lockup !== 1'b1) begin errors++; $display("FAIL lockup_flag got=%b want=1", lockup); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL lockup_valid got=%b want=0", valid); end
        strobe();
        checks++; if (dut.state !== 24'h3FFF5F) begin errors++; $display("FAIL lockup_adv_state got=%h want=3fff5f", dut.state); end
        checks++; if (lockup !== 1'b1) begin errors++; $display("FAIL lockup_sticky got=%b want=1", lockup); end
        seed = 24'h000005; seed_load = 1;
        cycle();
        seed_load = 0;
        checks++; if (lockup !== 1'b0) begin errors++; $display("FAIL lockup_clear got=%b want=0", lockup); end
        checks++; if (dut.state !== 24'h000005) begin errors++; $display("FAIL lockup_seed_state got=%h want=000005", dut.state); end
    endtask

    task automatic test_random();
        int advances = 0;
        int cyc = 0;
        int r = 0;
        logic se, sl;
        logic [23:0] sd;
        do_reset();
        while (advances < 4096 && cyc < 40000) begin
            if ((cyc % 97) == 0) r = $urandom_range(0, 3);
            se = 1'($urandom_range(0, 1));
            sl = ($urandom_range(0, 299) == 0);
            sd = ($urandom_range(0, 3) == 0) ? 24'h0 : 24'($urandom);
            rate = DIV_W'(r); step_en = se; seed_load = sl; seed = sd;
            cycle();
            model_clock(sl, sd, se, r);
            if (m_valid) advances++;
            checks++;
            if (ch_out !== ref_out()) begin
                errors++; $display("FAIL rand_ch_out cyc=%0d got=%h want=%h", cyc, ch_out, ref_out());
            end
            checks++;
            if (valid !== m_valid || dut.state !== m_state || lockup !== m_lock) begin
                errors++; $display("FAIL rand_ctrl cyc=%0d got v=%b s=%h l=%b want v=%b s=%h l=%b",
                                   cyc, valid, dut.state, lockup, m_valid, m_state, m_lock);
            end
            cyc++;
        end
        step_en = 0; seed_load = 0;
        checks++; if (advances < 4096) begin errors++; $display("FAIL rand_budget got=%0d want=4096 advances", advances); end
        @(posedge clk);
        #2 reset = 0;
        #1;
        checks++; if (ch_out !== '0) begin errors++; $display("FAIL async_reset_ch_out got=%h want=0", ch_out); end
        checks++; if (valid !== 1'b0 || lockup !== 1'b0) begin errors++; $display("FAIL async_reset_flags got v=%b l=%b want 0 0", valid, lockup); end
        checks++; if (dut.state !== SEED) begin errors++; $display("FAIL async_reset_state got=%h want=%h", dut.state, SEED); end
        cycle();
        reset = 1;
    endtask

    initial begin
        test_reset();
        test_first_step();
        test_rate_div();
        test_seed_load();
        test_lockup();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
